// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: pi1 bus op codes, command codes and mode bit positions shared by the pwm_multi files.
package pwm_multi_pkg;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi1_op_e;

  typedef enum logic [2:0] {
    CMD_SELECT   = 3'd0,
    CMD_PERIOD   = 3'd1,
    CMD_DUTY     = 3'd2,
    CMD_MODE     = 3'd3,
    CMD_PRESCALE = 3'd4,
    CMD_SYNC     = 3'd5,
    CMD_NOP6     = 3'd6,
    CMD_NOP7     = 3'd7
  } cmd_e;

  localparam int MODE_EN_BIT     = 0;
  localparam int MODE_CENTER_BIT = 1;
  localparam int MODE_INV_BIT    = 2;

  // Counter width: the command word keeps 3 bits for the opcode.
  function automatic int cnt_bits(input int archbitsz);
    return archbitsz - 3;
  endfunction

endpackage

// File: rtl/pwm_multi_chan.sv
// pwm_multi_chan: one PWM channel -- counter with direction, shadow/active period and duty, compare, output flop.
module pwm_multi_chan
  import pwm_multi_pkg::*;
#(
  parameter int CNTBITSZ = 29
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick,
  input  logic                sync,
  input  logic                wr_period,
  input  logic                wr_duty,
  input  logic                wr_mode,
  input  logic [CNTBITSZ-1:0] wdata,
  output logic                pwm
);

  localparam logic [CNTBITSZ-1:0] ONE_C = {{(CNTBITSZ-1){1'b0}}, 1'b1};

  logic [CNTBITSZ-1:0] cnt_r, cnt_s;
  logic [CNTBITSZ-1:0] sh_period_r, sh_period_s, sh_duty_r, sh_duty_s;
  logic [CNTBITSZ-1:0] act_period_r, act_period_s, act_duty_r, act_duty_s;
  logic [CNTBITSZ-1:0] period_eff_s;
  logic                dir_down_r, dir_down_s;
  logic                en_r, en_s, center_r, center_s, inv_r, inv_s;
  logic                pwm_r, pwm_s;
  logic                boundary_s;

  // Next-state: counter stepping, shadow commit at the period boundary, mode and shadow writes, compare.
  always_comb begin
    cnt_s        = cnt_r;
    dir_down_s   = dir_down_r;
    act_period_s = act_period_r;
    act_duty_s   = act_duty_r;
    en_s         = en_r;
    center_s     = center_r;
    inv_s        = inv_r;
    boundary_s   = tick && (cnt_r == '0) && (!center_r || !dir_down_r);
    // The step leaving the boundary already uses the freshly committed period.
    period_eff_s = boundary_s ? sh_period_r : act_period_r;

    if (!en_r || sync) begin
      cnt_s        = '0;
      dir_down_s   = 1'b0;
      act_period_s = sh_period_r;
      act_duty_s   = sh_duty_r;
    end else if (tick) begin
      if (boundary_s) begin
        act_period_s = sh_period_r;
        act_duty_s   = sh_duty_r;
      end else begin
        act_period_s = act_period_r;
        act_duty_s   = act_duty_r;
      end
      if (!center_r) begin
        if (cnt_r >= period_eff_s) cnt_s = '0;
        else cnt_s = cnt_r + ONE_C;
      end else if (!dir_down_r) begin
        if (cnt_r >= period_eff_s) dir_down_s = 1'b1;
        else cnt_s = cnt_r + ONE_C;
      end else begin
        if (cnt_r == '0) dir_down_s = 1'b0;
        else cnt_s = cnt_r - ONE_C;
      end
    end else begin
      cnt_s = cnt_r;
    end

    if (wr_mode) begin
      en_s       = wdata[MODE_EN_BIT];
      center_s   = wdata[MODE_CENTER_BIT];
      inv_s      = wdata[MODE_INV_BIT];
      dir_down_s = 1'b0;
    end else begin
      en_s     = en_r;
      center_s = center_r;
      inv_s    = inv_r;
    end

    sh_period_s = wr_period ? wdata : sh_period_r;
    sh_duty_s   = wr_duty ? wdata : sh_duty_r;

    if (en_r) pwm_s = (cnt_r < act_duty_r) ^ inv_r;
    else pwm_s = inv_r;
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r        <= '0;
      dir_down_r   <= 1'b0;
      sh_period_r  <= '0;
      sh_duty_r    <= '0;
      act_period_r <= '0;
      act_duty_r   <= '0;
      en_r         <= 1'b0;
      center_r     <= 1'b0;
      inv_r        <= 1'b0;
      pwm_r        <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      dir_down_r   <= dir_down_s;
      sh_period_r  <= sh_period_s;
      sh_duty_r    <= sh_duty_s;
      act_period_r <= act_period_s;
      act_duty_r   <= act_duty_s;
      en_r         <= en_s;
      center_r     <= center_s;
      inv_r        <= inv_s;
      pwm_r        <= pwm_s;
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM on the pi1 bus -- command decode, channel select, shared prescaler, read mux.
// Build option PWM_MULTI_SYNC_EN makes the SYNC command phase-align all enabled channels.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int  PWM_COUNT = 8,
  parameter int  CLKFREQ   = 1,
  parameter int  ARCHBITSZ = 32,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]   pi1_mapsz_o,
  input  logic [PWM_COUNT-1:0]   pwm_i,
  output logic [PWM_COUNT-1:0]   pwm_o
);

  localparam int CNTBITSZ = cnt_bits(ARCHBITSZ);
  localparam int RDW      = (PWM_COUNT < ARCHBITSZ) ? PWM_COUNT : ARCHBITSZ;
  localparam logic [ARCHBITSZ-1:0] CLKFREQ_C = ARCHBITSZ'(CLKFREQ);
  localparam logic [CNTBITSZ-1:0]  ONE_C     = {{(CNTBITSZ-1){1'b0}}, 1'b1};

  pi1_op_e               op_s;
  cmd_e                  cmd_s;
  logic [CNTBITSZ-1:0]   arg_s, wdata_s;
  logic [CNTBITSZ-1:0]   sel_r, prescale_r, presc_cnt_r;
  logic [ARCHBITSZ-1:0]  data_r, data_s, pwm_in_ext_s, pwm_out_ext_s;
  logic [PWM_COUNT-1:0]  pwm_s, wr_period_s, wr_duty_s, wr_mode_s;
  logic                  is_rw_s, is_wr_s, sel_ok_s, tick_s, sync_s;
  logic                  unused_s;

  assign op_s     = pi1_op_e'(pi1_op_i);
  assign cmd_s    = cmd_e'(pi1_data_i[2:0]);
  assign arg_s    = pi1_data_i[ARCHBITSZ-1:3];
  assign is_rw_s  = (op_s == PIRWOP);
  assign is_wr_s  = (op_s == PIWROP);
  assign sel_ok_s = (sel_r < CNTBITSZ'(PWM_COUNT));
  assign wdata_s  = is_wr_s ? pi1_data_i[CNTBITSZ-1:0] : arg_s;
  assign tick_s   = (presc_cnt_r >= prescale_r);
  assign unused_s = ^{pi1_addr_i, pi1_sel_i};

`ifdef PWM_MULTI_SYNC_EN
  assign sync_s = is_rw_s && (cmd_s == CMD_SYNC);
`else
  assign sync_s = 1'b0;
`endif

  // Read-data selection for the registered bus response.
  always_comb begin
    pwm_in_ext_s             = '0;
    pwm_in_ext_s[RDW-1:0]    = pwm_i[RDW-1:0];
    pwm_out_ext_s            = '0;
    pwm_out_ext_s[RDW-1:0]   = pwm_s[RDW-1:0];
    case (op_s)
      PIRDOP:  data_s = pwm_in_ext_s;
      PIWROP:  data_s = CLKFREQ_C;
      PIRWOP:  data_s = pwm_out_ext_s;
      default: data_s = data_r;
    endcase
  end

  // Bus response, channel select, prescale setting and the shared prescaler counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r      <= '0;
      sel_r       <= '0;
      prescale_r  <= '0;
      presc_cnt_r <= '0;
    end else begin
      data_r <= data_s;
      if (is_rw_s && (cmd_s == CMD_SELECT)) sel_r <= arg_s;
      if (is_rw_s && (cmd_s == CMD_PRESCALE)) prescale_r <= arg_s;
      if (sync_s || tick_s) presc_cnt_r <= '0;
      else presc_cnt_r <= presc_cnt_r + ONE_C;
    end
  end

  for (genvar i = 0; i < PWM_COUNT; i++) begin : g_chan
    logic hit_s;
    assign hit_s          = sel_ok_s && (sel_r == CNTBITSZ'(i));
    assign wr_period_s[i] = hit_s && is_rw_s && (cmd_s == CMD_PERIOD);
    assign wr_duty_s[i]   = hit_s && (is_wr_s || (is_rw_s && (cmd_s == CMD_DUTY)));
    assign wr_mode_s[i]   = hit_s && is_rw_s && (cmd_s == CMD_MODE);

    pwm_multi_chan #(
      .CNTBITSZ(CNTBITSZ)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick     (tick_s),
      .sync     (sync_s),
      .wr_period(wr_period_s[i]),
      .wr_duty  (wr_duty_s[i]),
      .wr_mode  (wr_mode_s[i]),
      .wdata    (wdata_s),
      .pwm      (pwm_s[i])
    );
  end

  assign pwm_o       = pwm_s;
  assign pi1_data_o  = data_r;
  assign pi1_rdy_o   = 1'b1;
  assign pi1_mapsz_o = {{(ADDRBITSZ-1){1'b0}}, 1'b1};

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for a 4-channel, 32-bit pwm_multi; bus vector table, directed waveform
// sequences and a randomized run compared every clock against a period/position reference model.
module tb_pwm_multi;

  localparam int N    = 4;
  localparam int CLKF = 50000000;
`ifdef PWM_MULTI_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [31:0] din, dout;
  logic [29:0] addr, mapsz;
  logic [3:0]  bsel, pin, pout;
  logic        rdy;

  always #5 clk = ~clk;

  pwm_multi #(.PWM_COUNT(N), .CLKFREQ(CLKF), .ARCHBITSZ(32)) dut (
    .clk_i(clk), .rst_i(rst), .pi1_op_i(op), .pi1_addr_i(addr), .pi1_data_i(din),
    .pi1_data_o(dout), .pi1_sel_i(bsel), .pi1_rdy_o(rdy), .pi1_mapsz_o(mapsz),
    .pwm_i(pin), .pwm_o(pout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a position k within a period of length L
  // (edge: L=P+1, counter=k; center: L=2P+2, counter rises 0..P then falls P..0).
  bit          m_en[N], m_ctr[N], m_inv[N];
  longint      m_k[N], m_ap[N], m_ad[N], m_sp[N], m_sd[N];
  longint      m_sel, m_ps, m_pc;
  logic [3:0]  m_pwm;
  logic [31:0] m_data;

  function automatic longint cntv(input longint k, input longint p, input bit ctr);
    if (ctr && (k > p)) return 2 * p + 1 - k;
    return k;
  endfunction

  task automatic model_step();
    bit         tick, sync, hit;
    logic [2:0] c;
    longint     arg, len, cv;
    logic [3:0] np;
    c   = din[2:0];
    arg = longint'(din[31:3]);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_ctr[i] = 0; m_inv[i] = 0;
        m_k[i] = 0; m_ap[i] = 0; m_ad[i] = 0; m_sp[i] = 0; m_sd[i] = 0;
      end
      m_sel = 0; m_ps = 0; m_pc = 0; m_pwm = 4'h0; m_data = 32'd0;
      return;
    end
    tick = (m_pc >= m_ps);
    sync = SYNC_EN && (op == 2'b11) && (c == 3'd5);
    for (int i = 0; i < N; i++)
      np[i] = m_en[i] ? ((cntv(m_k[i], m_ap[i], m_ctr[i]) < m_ad[i]) ^ m_inv[i]) : m_inv[i];
    case (op)
      2'b10:   m_data = {28'd0, pin};
      2'b01:   m_data = CLKF;
      2'b11:   m_data = {28'd0, m_pwm};
      default: m_data = m_data;
    endcase
    for (int i = 0; i < N; i++) begin
      if (!m_en[i] || sync) begin
        m_k[i] = 0; m_ap[i] = m_sp[i]; m_ad[i] = m_sd[i];
      end else if (tick) begin
        if (m_k[i] == 0) begin m_ap[i] = m_sp[i]; m_ad[i] = m_sd[i]; end
        len    = m_ctr[i] ? 2 * m_ap[i] + 2 : m_ap[i] + 1;
        m_k[i] = (m_k[i] + 1) % len;
      end
      hit = (m_sel == i);
      if (hit && op == 2'b11 && c == 3'd3) begin
        cv = cntv(m_k[i], m_ap[i], m_ctr[i]);
        m_en[i] = arg[0]; m_ctr[i] = arg[1]; m_inv[i] = arg[2];
        m_k[i] = cv;
      end
      if (hit && op == 2'b11 && c == 3'd1) m_sp[i] = arg;
      if (hit && op == 2'b01) m_sd[i] = longint'(din[28:0]);
      if (hit && op == 2'b11 && c == 3'd2) m_sd[i] = arg;
    end
    if (sync || tick) m_pc = 0;
    else m_pc++;
    if (op == 2'b11 && c == 3'd0) m_sel = arg;
    if (op == 2'b11 && c == 3'd4) m_ps = arg;
    m_pwm = np;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("model_pwm_o", pout, m_pwm);
    chk("model_pi1_data_o", dout, m_data);
  endtask

  task automatic bus(input logic [1:0] o, input logic [31:0] d);
    op = o; din = d;
    cycle();
    op = 2'b00; din = 32'd0;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [28:0] a);
    bus(2'b11, {a, c});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic measure(input int ch, input int n, output int highs, output int rises);
    logic prev;
    highs = 0; rises = 0; prev = pout[ch];
    repeat (n) begin
      cycle();
      if (pout[ch]) highs++;
      if (pout[ch] && !prev) rises++;
      prev = pout[ch];
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [3:0]  pin;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   h, r, bad, run, diff;
    bit   found;
    logic prev;

    vt[0] = '{2'b01, 32'd5,              4'h0, CLKF};
    vt[1] = '{2'b10, 32'd0,              4'hA, 32'd10};
    vt[2] = '{2'b10, 32'd0,              4'h5, 32'd5};
    vt[3] = '{2'b11, {29'd0, 3'd6},      4'h0, 32'd0};
    vt[4] = '{2'b11, {29'd3, 3'd7},      4'h0, 32'd0};
    vt[5] = '{2'b01, 32'hFFFF_FFFF,      4'hF, CLKF};

    rst = 1'b1; op = 2'b00; din = 32'd0; addr = 30'd0; bsel = 4'h0; pin = 4'h0;
    idle(2);
    chk("reset_pwm_o", pout, 4'h0);
    chk("reset_data_o", dout, 32'd0);
    chk("rdy_o", rdy, 1'b1);
    chk("mapsz_o", mapsz, 30'd1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pin = vt[i].pin;
      bus(vt[i].op, vt[i].data);
      chk($sformatf("bus_vec%0d", i), dout, vt[i].exp);
    end
    pin = 4'h0;

    // Edge-aligned: period 10, high 3.
    cmd(3'd0, 29'd0); cmd(3'd1, 29'd9); cmd(3'd2, 29'd3); cmd(3'd3, 29'd1);
    idle(12);
    measure(0, 40, h, r);
    chk("edge_highs", h, 12);
    chk("edge_rises", r, 4);

    // Center-aligned: period 10 clocks, 2+2 high around the bottom.
    cmd(3'd0, 29'd1); cmd(3'd1, 29'd4); cmd(3'd2, 29'd2); cmd(3'd3, 29'd3);
    idle(12);
    measure(1, 40, h, r);
    chk("center_highs", h, 16);
    chk("center_rises", r, 4);

    // Shadow duty written mid-period: only full 3- or 7-clock pulses may appear.
    cmd(3'd0, 29'd0);
    found = 1'b0; prev = pout[0];
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (pout[0] && !prev) found = 1'b1;
      prev = pout[0];
    end
    chk("shadow_edge_found", found, 1'b1);
    idle(3);
    cmd(3'd2, 29'd7);
    bad = 0; run = 0;
    repeat (40) begin
      cycle();
      if (pout[0]) run++;
      else begin
        if (run != 0 && run != 3 && run != 7) bad++;
        run = 0;
      end
    end
    chk("shadow_runt", bad, 0);
    measure(0, 40, h, r);
    chk("shadow_new_highs", h, 28);

    // Bounds, inversion and idle level.
    cmd(3'd2, 29'd0);  idle(22); measure(0, 20, h, r); chk("duty0_const_low", h, 0);
    cmd(3'd2, 29'd15); idle(22); measure(0, 20, h, r); chk("duty_gt_period_const_high", h, 20);
    cmd(3'd3, 29'd5);  idle(3);  measure(0, 20, h, r); chk("invert_duty15_low", h, 0);
    cmd(3'd2, 29'd0);  idle(22); measure(0, 20, h, r); chk("invert_duty0_high", h, 20);
    cmd(3'd3, 29'd4);  idle(2);  measure(0, 20, h, r); chk("disabled_idle_inverted", h, 20);
    cmd(3'd3, 29'd0);  idle(2);  measure(0, 20, h, r); chk("disabled_idle_low", h, 0);

    // Prescale 3 with period 1, duty 1: 4 clocks high, 4 low.
    cmd(3'd0, 29'd2); cmd(3'd1, 29'd1); cmd(3'd2, 29'd1); cmd(3'd4, 29'd3); cmd(3'd3, 29'd1);
    idle(20);
    measure(2, 40, h, r);
    chk("prescale_highs", h, 20);
    chk("prescale_rises", r, 5);
    cmd(3'd4, 29'd0);

    // Two channels enabled some clocks apart, then SYNC.
    cmd(3'd0, 29'd2); cmd(3'd3, 29'd0); cmd(3'd1, 29'd9); cmd(3'd2, 29'd3);
    cmd(3'd0, 29'd3); cmd(3'd3, 29'd0); cmd(3'd1, 29'd9); cmd(3'd2, 29'd3);
    cmd(3'd0, 29'd2); cmd(3'd3, 29'd1);
    idle(5);
    cmd(3'd0, 29'd3); cmd(3'd3, 29'd1);
    idle(12);
    cmd(3'd5, 29'd0);
    idle(1);
    diff = 0; h = 0;
    repeat (40) begin
      cycle();
      if (pout[2] != pout[3]) diff++;
      if (pout[2]) h++;
    end
    chk("sync_ch2_highs", h, 12);
`ifdef PWM_MULTI_SYNC_EN
    chk("sync_aligned", diff, 0);
`else
    chk("nosync_still_offset", (diff > 0), 1'b1);
`endif

    // Randomized traffic checked by the model every clock.
    for (int n = 0; n < 3000; n++) begin
      int         rr, kind;
      logic [2:0] c;
      logic [28:0] a;
      rr  = $urandom_range(0, 99);
      pin = 4'($urandom);
      if (rr < 1) begin
        rst = 1'b1; cycle(); rst = 1'b0;
      end else if (rr < 30) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          if ($urandom_range(0, 3) == 0) bus(2'b01, $urandom);
          else bus(2'b01, 32'($urandom_range(0, 15)));
        end else if (kind == 1) begin
          bus(2'b10, 32'd0);
        end else begin
          c = 3'($urandom_range(0, 7));
          case (c)
            3'd0:    a = 29'($urandom_range(0, 5));
            3'd1:    a = 29'($urandom_range(0, 12));
            3'd2:    a = 29'($urandom_range(0, 15));
            3'd3:    a = 29'($urandom_range(0, 7)) | 29'($urandom_range(0, 3) != 0);
            3'd4:    a = 29'($urandom_range(0, 3));
            default: a = 29'($urandom);
          endcase
          cmd(c, a);
        end
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
